// File: rtl/mlu_pkg.sv
// mlu_pkg: operation codes, controller state encoding and shared constants
// for the MLU sequencer and the Misc unit.
package mlu_pkg;

    typedef enum logic [2:0] {
        OP_COUNTER = 3'd0,
        OP_ADDER   = 3'd1,
        OP_MUL     = 3'd2,
        OP_ACC     = 3'd3,
        OP_NONLIN  = 3'd4,
        OP_KSORT   = 3'd5
    } mlu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_MISC   = 3'd4,
        ST_DONE   = 3'd5
    } mlu_ctrl_state_e;

    // Misc-unit latency (K); the controller's MISC wait defaults to it.
    localparam int MLU_K = 20;

    // Ops that accumulate across chunks and need CLEAR/DRAIN.
    function automatic logic is_acc_op(input logic [2:0] op);
        return (op >= OP_ACC) && (op <= OP_KSORT);
    endfunction

    // Lane-wise ops that produce one result per chunk.
    function automatic logic is_vec_op(input logic [2:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/mlu_addr_gen.sv
// mlu_addr_gen: hot/cold operand-buffer address stepper. Loads the base
// addresses and chunk count on a new command, advances both addresses on
// every read (wrapping at 2^ADDR_WIDTH) and flags the final read.
module mlu_addr_gen
    import mlu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] hot_base_i,
    input  logic [ADDR_WIDTH-1:0] cold_base_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic [ADDR_WIDTH-1:0] hot_addr_o,
    output logic [ADDR_WIDTH-1:0] cold_addr_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] hot_q, hot_d;
    logic [ADDR_WIDTH-1:0] cold_q, cold_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;

    // Next-state: load wins over step; a zero length runs as a single chunk.
    always_comb begin
        hot_d  = hot_q;
        cold_d = cold_q;
        rem_d  = rem_q;
        if (load_i) begin
            hot_d  = hot_base_i;
            cold_d = cold_base_i;
            rem_d  = (len_i == '0) ? LEN_WIDTH'(1) : len_i;
        end else if (step_i) begin
            hot_d  = hot_q + ADDR_WIDTH'(1);
            cold_d = cold_q + ADDR_WIDTH'(1);
            rem_d  = rem_q - LEN_WIDTH'(1);
        end
    end

    // Address and remaining-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hot_q  <= '0;
            cold_q <= '0;
            rem_q  <= '0;
        end else begin
            hot_q  <= hot_d;
            cold_q <= cold_d;
            rem_q  <= rem_d;
        end
    end

    assign hot_addr_o  = hot_q;
    assign cold_addr_o = cold_q;
    assign last_o      = (rem_q == LEN_WIDTH'(1));

endmodule

// File: rtl/mlu_ctrl.sv
// mlu_ctrl: command-driven sequencer for the MLU datapath. Accepts one
// descriptor at a time, streams chunk reads from the operand buffers and
// drives all MLU control inputs plus the result-valid strobes.
// Optional feature macro: MLU_CTRL_PERF_EN adds saturating busy-cycle and
// retired-command counters.
module mlu_ctrl
    import mlu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int LEN_WIDTH    = 10,
    parameter int DRAIN_CYCLES = 2,
    parameter int MISC_CYCLES  = MLU_K
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [ADDR_WIDTH-1:0] cmd_hot_base,
    input  logic [ADDR_WIDTH-1:0] cmd_cold_base,
    input  logic                  cmd_sel_in,
    input  logic                  cmd_asce,
    input  logic [2:0]            cmd_fun_id,
    output logic                  buf_rd_en,
    output logic [ADDR_WIDTH-1:0] hot_addr,
    output logic [ADDR_WIDTH-1:0] cold_addr,
    output logic [2:0]            mlu_sel_output,
    output logic                  mlu_sel_in,
    output logic                  mlu_isStop,
    output logic                  mlu_clear_reg,
    output logic                  mlu_is_start,
    output logic                  mlu_asce,
    output logic [2:0]            mlu_fun_id,
    output logic                  res_valid,
    output logic                  res_last,
    output logic                  busy,
    output logic                  done
`ifdef MLU_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_busy_cycles,
    output logic [31:0]           perf_cmds
`endif
);

    localparam int CNT_W = $clog2(MISC_CYCLES + 1);
    // Counter values at which DRAIN/MISC fire their strobes and exit.
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_PRE  = CNT_W'(DRAIN_CYCLES - 2);
    localparam logic [CNT_W-1:0] MISC_LAST  = CNT_W'(MISC_CYCLES);
    localparam logic [CNT_W-1:0] MISC_PRE   = CNT_W'(MISC_CYCLES - 1);

    mlu_ctrl_state_e state_q;
    logic [2:0]      op_q;
    logic            sel_in_q;
    logic            asce_q;
    logic [2:0]      fun_id_q;
    logic            cmd_ready_q;
    logic            busy_q;
    logic            done_q;
    logic            buf_rd_en_q;
    logic            clear_reg_q;
    logic            is_start_q;
    logic            is_stop_q;
    logic            res_valid_q;
    logic            res_last_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept;
    logic ag_last;

    assign accept = cmd_valid && cmd_ready_q;

    mlu_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .step_i      (buf_rd_en_q),
        .hot_base_i  (cmd_hot_base),
        .cold_base_i (cmd_cold_base),
        .len_i       (cmd_len),
        .hot_addr_o  (hot_addr),
        .cold_addr_o (cold_addr),
        .last_o      (ag_last)
    );

    // Sequencer FSM; every output is registered and set one edge ahead of
    // the cycle in which it must be visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            sel_in_q    <= 1'b0;
            asce_q      <= 1'b0;
            fun_id_q    <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            buf_rd_en_q <= 1'b0;
            clear_reg_q <= 1'b0;
            is_start_q  <= 1'b0;
            is_stop_q   <= 1'b1;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            done_q      <= 1'b0;
            clear_reg_q <= 1'b0;
            is_start_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            // Acc sees valid chunks one cycle after the read strobe.
            is_stop_q   <= !(buf_rd_en_q && is_acc_op(op_q));
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= cmd_op;
                        sel_in_q    <= cmd_sel_in;
                        asce_q      <= cmd_asce;
                        fun_id_q    <= cmd_fun_id;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (is_acc_op(cmd_op)) begin
                            state_q     <= ST_CLEAR;
                            clear_reg_q <= 1'b1;
                        end else if (is_vec_op(cmd_op)) begin
                            state_q     <= ST_STREAM;
                            buf_rd_en_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    state_q     <= ST_STREAM;
                    buf_rd_en_q <= 1'b1;
                end
                ST_STREAM: begin
                    if (!is_acc_op(op_q)) begin
                        res_valid_q <= 1'b1;
                        res_last_q  <= ag_last;
                    end
                    if (ag_last) begin
                        buf_rd_en_q <= 1'b0;
                        if (is_acc_op(op_q)) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= '0;
                            if (op_q == OP_ACC && DRAIN_CYCLES == 1) begin
                                res_valid_q <= 1'b1;
                                res_last_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_q <= '0;
                        if (op_q == OP_ACC) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_MISC;
                            is_start_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (op_q == OP_ACC && cnt_q == DRAIN_PRE) begin
                            res_valid_q <= 1'b1;
                            res_last_q  <= 1'b1;
                        end
                    end
                end
                ST_MISC: begin
                    if (cnt_q == MISC_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == MISC_PRE) begin
                            res_valid_q <= 1'b1;
                            res_last_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign buf_rd_en      = buf_rd_en_q;
    assign mlu_sel_output = op_q;
    assign mlu_sel_in     = sel_in_q;
    assign mlu_asce       = asce_q;
    assign mlu_fun_id     = fun_id_q;
    assign mlu_isStop     = is_stop_q;
    assign mlu_clear_reg  = clear_reg_q;
    assign mlu_is_start   = is_start_q;
    assign res_valid      = res_valid_q;
    assign res_last       = res_last_q;

`ifdef MLU_CTRL_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_cmds_q;

    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_q <= '0;
            perf_cmds_q <= '0;
        end else begin
            if (busy_q && perf_busy_q != '1) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (done_q && perf_cmds_q != '1) begin
                perf_cmds_q <= perf_cmds_q + 32'd1;
            end
        end
    end

    assign perf_busy_cycles = perf_busy_q;
    assign perf_cmds        = perf_cmds_q;
`endif

endmodule

// File: tb/tb_mlu_ctrl.sv
// tb_mlu_ctrl: directed table-driven bench for mlu_ctrl plus hand-written
// sequences for reset abort and back-to-back command queuing.
module tb_mlu_ctrl;

    localparam int AW = 10;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] cmd_hot_base;
    logic [AW-1:0] cmd_cold_base;
    logic          cmd_sel_in;
    logic          cmd_asce;
    logic [2:0]    cmd_fun_id;
    logic          buf_rd_en;
    logic [AW-1:0] hot_addr;
    logic [AW-1:0] cold_addr;
    logic [2:0]    mlu_sel_output;
    logic          mlu_sel_in;
    logic          mlu_isStop;
    logic          mlu_clear_reg;
    logic          mlu_is_start;
    logic          mlu_asce;
    logic [2:0]    mlu_fun_id;
    logic          res_valid;
    logic          res_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mlu_ctrl #(
        .ADDR_WIDTH   (AW),
        .LEN_WIDTH    (LW),
        .DRAIN_CYCLES (2),
        .MISC_CYCLES  (20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_len        (cmd_len),
        .cmd_hot_base   (cmd_hot_base),
        .cmd_cold_base  (cmd_cold_base),
        .cmd_sel_in     (cmd_sel_in),
        .cmd_asce       (cmd_asce),
        .cmd_fun_id     (cmd_fun_id),
        .buf_rd_en      (buf_rd_en),
        .hot_addr       (hot_addr),
        .cold_addr      (cold_addr),
        .mlu_sel_output (mlu_sel_output),
        .mlu_sel_in     (mlu_sel_in),
        .mlu_isStop     (mlu_isStop),
        .mlu_clear_reg  (mlu_clear_reg),
        .mlu_is_start   (mlu_is_start),
        .mlu_asce       (mlu_asce),
        .mlu_fun_id     (mlu_fun_id),
        .res_valid      (res_valid),
        .res_last       (res_last),
        .busy           (busy),
        .done           (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reset image of all outputs, MSB first:
    // ready, rd_en, hot, cold, sel_out, sel_in, isStop, clear, start, asce, fun, rv, rl, busy, done
    function automatic longint out_vec();
        return longint'({cmd_ready, buf_rd_en, hot_addr, cold_addr, mlu_sel_output, mlu_sel_in,
                         mlu_isStop, mlu_clear_reg, mlu_is_start, mlu_asce, mlu_fun_id,
                         res_valid, res_last, busy, done});
    endfunction

    longint rst_img;

    typedef struct {
        logic [2:0]    op;
        logic [LW-1:0] len;
        logic [AW-1:0] hot;
        logic [AW-1:0] cold;
        logic [2:0]    fun;
        logic          asce;
        logic          sel_in;
        int            reads;
        int            res;
        int            first_res;
        int            last_res;
        int            done_at;
        int            clears;
        int            stop_low;
        int            start_at;
    } vec_t;

    vec_t vt[8];

    initial begin
        rst_img = longint'({1'b1, 1'b0, 10'd0, 10'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                            3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        // Offsets are cycles after the accept edge (k=1 is the first cycle after it).
        //          op    len     hot      cold     fun  asce sel  rd res 1st last done clr stp start
        vt[0] = '{3'd0, 10'd4, 10'h3FE, 10'h010, 3'd1, 1'b0, 1'b1, 4, 4, 2,  5,  5, 0, 0, 0};
        vt[1] = '{3'd3, 10'd3, 10'h100, 10'h3FF, 3'd2, 1'b0, 1'b0, 3, 1, 6,  6,  7, 1, 3, 0};
        vt[2] = '{3'd5, 10'd2, 10'h020, 10'h040, 3'd0, 1'b1, 1'b0, 2, 1, 26, 26, 27, 1, 2, 6};
        vt[3] = '{3'd1, 10'd0, 10'h3FF, 10'h000, 3'd3, 1'b0, 1'b1, 1, 1, 2,  2,  2, 0, 0, 0};
        vt[4] = '{3'd7, 10'd5, 10'h011, 10'h022, 3'd4, 1'b1, 1'b1, 0, 0, 0,  0,  1, 0, 0, 0};
        vt[5] = '{3'd4, 10'd1, 10'h200, 10'h201, 3'd5, 1'b0, 1'b1, 1, 1, 25, 25, 26, 1, 1, 5};
        vt[6] = '{3'd2, 10'd3, 10'h3FD, 10'h3FE, 3'd6, 1'b1, 1'b0, 3, 3, 2,  4,  4, 0, 0, 0};
        vt[7] = '{3'd6, 10'd0, 10'h001, 10'h002, 3'd7, 1'b0, 1'b0, 0, 0, 0,  0,  1, 0, 0, 0};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_hot_base = '0; cmd_cold_base = '0;
        cmd_sel_in = 1'b0; cmd_asce = 1'b0; cmd_fun_id = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", out_vec(), rst_img);

        // Table-driven commands
        for (int v = 0; v < 8; v++) begin
            int reads, res, first_res, last_res, lasts, stray, done_at, clears;
            int stop_low, starts, start_at, addr_err, not_busy, ready_hi, asce_err;
            logic [AW-1:0] eh, ec;
            logic [2:0] sel_o, fun_o;
            logic asce_o, sel_in_o;
            reads = 0; res = 0; first_res = 0; last_res = 0; lasts = 0; stray = 0;
            done_at = 0; clears = 0; stop_low = 0; starts = 0; start_at = 0;
            addr_err = 0; not_busy = 0; ready_hi = 0; asce_err = 0;
            sel_o = '0; fun_o = '0; asce_o = 1'b0; sel_in_o = 1'b0;

            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_op = vt[v].op; cmd_len = vt[v].len;
            cmd_hot_base = vt[v].hot; cmd_cold_base = vt[v].cold;
            cmd_fun_id = vt[v].fun; cmd_asce = vt[v].asce; cmd_sel_in = vt[v].sel_in;
            @(negedge clk);
            check($sformatf("v%0d_ready_before", v), cmd_ready, 1);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            for (int k = 1; k <= 60 && done_at == 0; k++) begin
                @(negedge clk);
                if (buf_rd_en) begin
                    eh = vt[v].hot + AW'(reads);
                    ec = vt[v].cold + AW'(reads);
                    if (hot_addr !== eh || cold_addr !== ec) addr_err++;
                    reads++;
                end
                if (res_valid) begin
                    res++;
                    if (first_res == 0) first_res = k;
                    if (res_last) begin lasts++; last_res = k; end
                end else if (res_last) begin
                    stray++;
                end
                if (mlu_clear_reg) clears++;
                if (!mlu_isStop) stop_low++;
                if (mlu_is_start) begin starts++; start_at = k; end
                if (busy !== 1'b1) not_busy++;
                if (cmd_ready) ready_hi++;
                if (mlu_asce !== vt[v].asce) asce_err++;
                if (done) begin
                    done_at = k;
                    sel_o = mlu_sel_output; fun_o = mlu_fun_id;
                    asce_o = mlu_asce; sel_in_o = mlu_sel_in;
                end
            end
            check($sformatf("v%0d_done_cycle", v), done_at, vt[v].done_at);
            check($sformatf("v%0d_reads", v), reads, vt[v].reads);
            check($sformatf("v%0d_addr_errors", v), addr_err, 0);
            check($sformatf("v%0d_res_count", v), res, vt[v].res);
            check($sformatf("v%0d_first_res", v), first_res, vt[v].first_res);
            check($sformatf("v%0d_last_res", v), last_res, vt[v].last_res);
            check($sformatf("v%0d_last_count", v), lasts, (vt[v].res > 0) ? 1 : 0);
            check($sformatf("v%0d_stray_last", v), stray, 0);
            check($sformatf("v%0d_clear_pulses", v), clears, vt[v].clears);
            check($sformatf("v%0d_isstop_low", v), stop_low, vt[v].stop_low);
            check($sformatf("v%0d_start_cycle", v), start_at, vt[v].start_at);
            check($sformatf("v%0d_start_count", v), starts, (vt[v].start_at > 0) ? 1 : 0);
            check($sformatf("v%0d_not_busy", v), not_busy, 0);
            check($sformatf("v%0d_ready_while_busy", v), ready_hi, 0);
            check($sformatf("v%0d_asce_hold", v), asce_err, 0);
            check($sformatf("v%0d_sel_output", v), sel_o, vt[v].op);
            check($sformatf("v%0d_fun_id", v), fun_o, vt[v].fun);
            check($sformatf("v%0d_asce", v), asce_o, vt[v].asce);
            check($sformatf("v%0d_sel_in", v), sel_in_o, vt[v].sel_in);
            @(negedge clk);
            check($sformatf("v%0d_ready_after", v), cmd_ready, 1);
            check($sformatf("v%0d_busy_after", v), busy, 0);
            check($sformatf("v%0d_done_after", v), done, 0);
        end

        // Reset in the middle of a len-8 op-2 stream aborts the command
        begin
            int bad_done, bad_res;
            bad_done = 0; bad_res = 0;
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_op = 3'd2; cmd_len = 10'd8;
            cmd_hot_base = 10'h0A0; cmd_cold_base = 10'h0B0;
            cmd_fun_id = 3'd3; cmd_asce = 1'b1; cmd_sel_in = 1'b1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(posedge clk); @(posedge clk); #1;
            check("abort_streaming", {busy, buf_rd_en}, 2'b11);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check("abort_reset_outputs", out_vec(), rst_img);
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (done) bad_done++;
                if (res_valid || buf_rd_en) bad_res++;
            end
            check("abort_no_done", bad_done, 0);
            check("abort_no_activity", bad_res, 0);
            check("abort_ready", cmd_ready, 1);
        end

        // Two commands queued with cmd_valid held high
        begin
            int first_done, second_done, acc2, overlap, reads, ndone;
            logic [2:0] sel1, sel2;
            first_done = 0; second_done = 0; acc2 = 0; overlap = 0; reads = 0; ndone = 0;
            sel1 = 3'd7; sel2 = 3'd7;
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_op = 3'd0; cmd_len = 10'd2;
            cmd_hot_base = 10'h050; cmd_cold_base = 10'h060;
            cmd_fun_id = 3'd1; cmd_asce = 1'b0; cmd_sel_in = 1'b0;
            @(posedge clk); #1;
            cmd_op = 3'd1; cmd_len = 10'd1; cmd_hot_base = 10'h070;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (busy && cmd_ready) overlap++;
                if (buf_rd_en) reads++;
                if (done) begin
                    ndone++;
                    if (ndone == 1) begin first_done = k; sel1 = mlu_sel_output; end
                    else begin second_done = k; sel2 = mlu_sel_output; end
                end
                if (cmd_valid && cmd_ready && acc2 == 0) begin
                    acc2 = k;
                    @(posedge clk); #1;
                    cmd_valid = 1'b0;
                end
            end
            cmd_valid = 1'b0;
            check("b2b_first_done", first_done, 3);
            check("b2b_second_accept", acc2, 4);
            check("b2b_second_done", second_done, 6);
            check("b2b_done_count", ndone, 2);
            check("b2b_ready_while_busy", overlap, 0);
            check("b2b_reads", reads, 3);
            check("b2b_first_op_kept", sel1, 0);
            check("b2b_second_op", sel2, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
